// File: rtl/pspi_tx_frame_if.sv
// Bus between the PSPI transmit framer, its requester and the SCLK generator/slave side.
interface pspi_tx_frame_if;
  logic       start;
  logic [7:0] tx_data;
  logic       sclk;
  logic       select;
  logic       miso;
  logic       run;
  logic       mosi;
  logic       error_control;
  logic       busy;
  logic       done;
  logic       fail;
  logic [1:0] tries;

  modport master (
    output start, tx_data, sclk, select, miso,
    input  run, mosi, error_control, busy, done, fail, tries
  );

  modport slave (
    input  start, tx_data, sclk, select, miso,
    output run, mosi, error_control, busy, done, fail, tries
  );
endinterface

// File: rtl/pspi_tx_frame.sv
// PSPI transmit framer: byte + parity + ACK slot, with NACK-driven retransmit.
// Define PSPI_ODD_PARITY_EN for odd parity; even parity otherwise.
module pspi_tx_frame #(
  parameter int MAX_FRAMES = 4
) (
  input logic             clk_in,
  input logic             rst,
  pspi_tx_frame_if.slave  bus
);

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    LAUNCH,
    WAIT_SEL,
    SHIFT,
    RESOLVE
  } state_t;

  localparam logic [1:0] LAST_TRY = 2'(MAX_FRAMES - 1);

  state_t     state;
  logic       sclk_q;
  logic       select_q;
  logic [7:0] data_q;
  logic       parity_q;
  logic [3:0] rise_cnt;
  logic       parity_next;
  logic       slot_bit;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       select_rise;

`ifdef PSPI_ODD_PARITY_EN
  assign parity_next = ~^bus.tx_data;
`else
  assign parity_next = ^bus.tx_data;
`endif

  assign sclk_rise   = bus.sclk & ~sclk_q;
  assign sclk_fall   = ~bus.sclk & sclk_q;
  assign select_rise = bus.select & ~select_q;

  // After rise k the counter holds k, so the next fall launches slot k.
  always_comb begin
    slot_bit = 1'b0;
    if (rise_cnt < 4'd8)
      slot_bit = data_q[~rise_cnt[2:0]];
    else if (rise_cnt == 4'd8)
      slot_bit = parity_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state             <= SYNC;
      sclk_q            <= 1'b0;
      select_q          <= 1'b1;
      data_q            <= 8'd0;
      parity_q          <= 1'b0;
      rise_cnt          <= 4'd0;
      bus.run           <= 1'b0;
      bus.mosi          <= 1'b0;
      bus.error_control <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.fail          <= 1'b0;
      bus.tries         <= 2'd0;
    end else begin
      sclk_q   <= bus.sclk;
      select_q <= bus.select;
      bus.run  <= 1'b0;
      bus.done <= 1'b0;
      bus.fail <= 1'b0;
      case (state)
        SYNC: begin
          if (bus.select && !bus.sclk)
            state <= IDLE;
        end
        IDLE: begin
          if (bus.start) begin
            data_q            <= bus.tx_data;
            parity_q          <= parity_next;
            bus.tries         <= 2'd0;
            bus.error_control <= 1'b0;
            bus.busy          <= 1'b1;
            bus.run           <= 1'b1;
            bus.mosi          <= bus.tx_data[7];
            state             <= LAUNCH;
          end
        end
        LAUNCH: state <= WAIT_SEL;
        WAIT_SEL: begin
          if (!bus.select) begin
            rise_cnt <= 4'd0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          // A select rise with rise_cnt at 0 is the inter-frame gap of a retry.
          if (select_rise && rise_cnt != 4'd0) begin
            bus.fail          <= 1'b1;
            bus.busy          <= 1'b0;
            bus.error_control <= 1'b0;
            state             <= IDLE;
          end else if (sclk_rise) begin
            if (rise_cnt < 4'd10)
              rise_cnt <= rise_cnt + 4'd1;
            if (rise_cnt == 4'd9)
              bus.error_control <= bus.miso;
          end else if (sclk_fall) begin
            if (rise_cnt == 4'd10)
              state <= RESOLVE;
            else if (rise_cnt != 4'd0)
              bus.mosi <= slot_bit;
          end
        end
        RESOLVE: begin
          if (!bus.error_control) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (bus.tries < LAST_TRY) begin
            bus.tries <= bus.tries + 2'd1;
            rise_cnt  <= 4'd0;
            bus.mosi  <= data_q[7];
            state     <= SHIFT;
          end else begin
            bus.fail          <= 1'b1;
            bus.busy          <= 1'b0;
            bus.error_control <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_pspi_tx_frame.sv
// Self-checking bench for pspi_tx_frame: models the SCLK generator and slave,
// and checks every frame against a reference built from the framing rules.
module tb_pspi_tx_frame;

  localparam int MAX_FRAMES = 4;
  localparam int HALF       = 4;

  typedef struct {
    logic [7:0] data;
    logic [3:0] nack;
    int         abort_rise;
    int         exp_frames;
    bit         exp_done;
    bit         exp_fail;
    logic [1:0] exp_tries;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst;
  pspi_tx_frame_if bus ();

  pspi_tx_frame #(.MAX_FRAMES(MAX_FRAMES)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int         vectors     = 0;
  int         miscompares = 0;
  int         run_cnt     = 0;
  int         done_cnt    = 0;
  int         fail_cnt    = 0;
  logic [1:0] end_tries   = 2'd0;
  logic       end_busy    = 1'b0;
  vec_t       table_v[6];

  always @(negedge clk_in) begin
    if (bus.run) run_cnt++;
    if (bus.done) begin
      done_cnt++;
      end_tries = bus.tries;
      end_busy  = bus.busy;
    end
    if (bus.fail) begin
      fail_cnt++;
      end_tries = bus.tries;
      end_busy  = bus.busy;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Serial image of one frame in slot order, slot 0 in the MSB.
  function automatic logic [9:0] model_frame(input logic [7:0] data);
    logic par;
    par = ($countones(data) % 2) == 1;
`ifdef PSPI_ODD_PARITY_EN
    par = ~par;
`endif
    return {data, par, 1'b0};
  endfunction

  function automatic vec_t model_vector(input logic [7:0] data, input logic [3:0] nack);
    vec_t v;
    v.data       = data;
    v.nack       = nack;
    v.abort_rise = 0;
    v.exp_frames = MAX_FRAMES;
    v.exp_done   = 1'b0;
    v.exp_fail   = 1'b1;
    for (int f = 0; f < MAX_FRAMES; f++) begin
      if (!nack[f]) begin
        v.exp_frames = f + 1;
        v.exp_done   = 1'b1;
        v.exp_fail   = 1'b0;
        break;
      end
    end
    v.exp_tries = 2'(v.exp_frames - 1);
    return v;
  endfunction

  task automatic applyStimulus(input logic [7:0] data);
    @(negedge clk_in);
    bus.tx_data = data;
    bus.start   = 1'b1;
    @(negedge clk_in);
    bus.start = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    logic [9:0] got;
    logic       ec_at_fall;
    bit         aborted = 0;
    int         frames  = 0;
    run_cnt  = 0;
    done_cnt = 0;
    fail_cnt = 0;
    applyStimulus(v.data);
    checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
    checkOutput("run_in_launch", 32'(bus.run), 32'd1);
    for (int f = 0; f < MAX_FRAMES; f++) begin
      @(negedge clk_in);
      bus.select = 1'b0;
      repeat (HALF) @(negedge clk_in);
      got        = 10'd0;
      ec_at_fall = 1'b0;
      for (int k = 1; k <= 10; k++) begin
        if (k == 10) bus.miso = v.nack[f];
        got      = {got[8:0], bus.mosi};
        bus.sclk = 1'b1;
        if (f == 0 && k == v.abort_rise) begin
          @(negedge clk_in);
          bus.select = 1'b1;
          @(negedge clk_in);
          bus.sclk = 1'b0;
          aborted  = 1;
          break;
        end
        repeat (HALF) @(negedge clk_in);
        if (k == 10) ec_at_fall = bus.error_control;
        bus.sclk = 1'b0;
        repeat (HALF) @(negedge clk_in);
      end
      bus.select = 1'b1;
      bus.miso   = 1'b0;
      frames++;
      if (aborted) break;
      checkOutput("frame_bits", 32'(got), 32'(model_frame(v.data)));
      checkOutput("nack_flag", 32'(ec_at_fall), 32'(v.nack[f]));
      if (!ec_at_fall || f == MAX_FRAMES - 1) break;
      repeat (HALF) @(negedge clk_in);
      checkOutput("ec_held_between_frames", 32'(bus.error_control), 32'd1);
    end
    for (int i = 0; i < 20 && (done_cnt + fail_cnt) == 0; i++) @(negedge clk_in);
    repeat (2) @(negedge clk_in);
    checkOutput("frames_sent", 32'(frames), 32'(v.exp_frames));
    checkOutput("run_pulses", 32'(run_cnt), 32'd1);
    checkOutput("done_pulses", 32'(done_cnt), 32'(v.exp_done));
    checkOutput("fail_pulses", 32'(fail_cnt), 32'(v.exp_fail));
    checkOutput("tries_at_end", 32'(end_tries), 32'(v.exp_tries));
    checkOutput("busy_at_end_pulse", 32'(end_busy), 32'd0);
    checkOutput("busy_after", 32'(bus.busy), 32'd0);
    checkOutput("ec_after", 32'(bus.error_control), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    checkOutput(name, 32'({bus.run, bus.mosi, bus.error_control, bus.busy,
                           bus.done, bus.fail, bus.tries}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    table_v[0] = '{8'hA5, 4'b0000, 0, 1, 1'b1, 1'b0, 2'd0};
    table_v[1] = '{8'h01, 4'b0011, 0, 3, 1'b1, 1'b0, 2'd2};
    table_v[2] = '{8'hFF, 4'b1111, 0, 4, 1'b0, 1'b1, 2'd3};
    table_v[3] = '{8'h00, 4'b0001, 0, 2, 1'b1, 1'b0, 2'd1};
    table_v[4] = '{8'h80, 4'b0111, 0, 4, 1'b1, 1'b0, 2'd3};
    table_v[5] = '{8'h5A, 4'b0000, 5, 1, 1'b0, 1'b1, 2'd0};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.tx_data = 8'h00;
    bus.sclk    = 1'b0;
    bus.select  = 1'b1;
    bus.miso    = 1'b0;
    repeat (3) @(negedge clk_in);
    check_reset_outputs("reset_values");
    rst = 1'b0;
    repeat (2) @(negedge clk_in);

    for (int i = 0; i < 6; i++) runVector(table_v[i]);

    for (int i = 0; i < 10; i++)
      runVector(model_vector(8'($urandom), 4'($urandom_range(0, 15))));

    // Reset during slot 4, then start must wait for the generator to go idle.
    applyStimulus(8'h3C);
    @(negedge clk_in);
    bus.select = 1'b0;
    repeat (HALF) @(negedge clk_in);
    for (int k = 1; k <= 4; k++) begin
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk_in);
      bus.sclk = 1'b0;
      repeat (HALF) @(negedge clk_in);
    end
    rst = 1'b1;
    @(negedge clk_in);
    check_reset_outputs("reset_mid_frame");
    rst     = 1'b0;
    run_cnt = 0;
    applyStimulus(8'hC3);
    repeat (3) @(negedge clk_in);
    checkOutput("start_ignored_busy", 32'(bus.busy), 32'd0);
    checkOutput("start_ignored_run", 32'(run_cnt), 32'd0);
    bus.select = 1'b1;
    repeat (2) @(negedge clk_in);
    runVector(model_vector(8'h3C, 4'b0000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
